// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator for a Sobel kernel: two line buffers plus a
// shifting 3x3 register window, one window per accepted interior pixel.
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  output logic       out_valid,
  output logic       out_last,
  output logic [7:0] p0,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] p4,
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    lb_a [IMG_W];   // row r-2
  logic [7:0]    lb_b [IMG_W];   // row r-1
  logic [7:0]    top_new, mid_new;
  logic [2:0][2:0][7:0] win;     // [window row][window col], col 0 is leftmost
  logic          accept;

  assign accept  = in_valid && !rst;
  assign top_new = lb_a[col];
  assign mid_new = lb_b[col];

  // Line buffers carry no reset; the row >= 2 gate hides stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a[col] <= lb_b[col];
      lb_b[col] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      win       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= in_valid && (col >= COL_TWO) && (row >= ROW_TWO);
      out_last  <= in_valid && (col == COL_MAX) && (row == ROW_MAX);
      if (in_valid) begin
        win[0][0] <= win[0][1];
        win[0][1] <= win[0][2];
        win[0][2] <= top_new;
        win[1][0] <= win[1][1];
        win[1][1] <= win[1][2];
        win[1][2] <= mid_new;
        win[2][0] <= win[2][1];
        win[2][1] <= win[2][2];
        win[2][2] <= in_pixel;
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign p0 = win[0][0];
  assign p1 = win[0][1];
  assign p2 = win[0][2];
  assign p3 = win[1][0];
  assign p4 = win[1][1];
  assign p5 = win[1][2];
  assign p6 = win[2][0];
  assign p7 = win[2][1];
  assign p8 = win[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench: a 4x4 instance runs directed scenarios, a 64x64 instance a
// random frame; a frame-array reference model predicts every window.
module tb_sobel_window_gen;
  typedef struct {
    logic [71:0] pix;
    logic        last;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int W = (g == 0) ? 4 : 64;
    localparam int H = W;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = '0;
    logic       out_valid, out_last;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

    logic [7:0] img [H][W];
    int   mc = 0, mr = 0;
    win_t q[$];
    win_t seen[$];
    bit   exp_v = 1'b0, exp_r = 1'b0, done = 1'b0;
    int   nwin = 0, nlast = 0;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
      .out_valid(out_valid), .out_last(out_last),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
      .p5(p5), .p6(p6), .p7(p7), .p8(p8)
    );

    // One clock of stimulus; the model tracks the frame as a plain image array.
    task automatic cyc(input logic r, input logic v, input logic [7:0] pix);
      win_t w;
      bit nxt;
      nxt = 1'b0;
      rst = r; in_valid = v; in_pixel = pix;
      if (r) begin
        mc = 0; mr = 0;
      end else if (v) begin
        img[mr][mc] = pix;
        if (mc >= 2 && mr >= 2) begin
          for (int k = 0; k < 9; k++) w.pix[71-8*k -: 8] = img[mr-2+k/3][mc-2+k%3];
          w.last = (mc == W-1) && (mr == H-1);
          q.push_back(w);
          nxt = 1'b1;
        end
        if (mc == W-1) begin
          mc = 0;
          mr = (mr == H-1) ? 0 : mr + 1;
        end else mc++;
      end
      @(posedge clk);
      exp_v = nxt; exp_r = r;
      #1;
    endtask

    // mode 0: continuous, 1: alternating idle, 2: random idle gaps
    task automatic frame(input logic [7:0] base, input int mode, input bit rnd);
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          if (mode == 1) cyc(1'b0, 1'b0, 8'($urandom));
          if (mode == 2) repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 8'($urandom));
          cyc(1'b0, 1'b1, rnd ? 8'($urandom) : 8'(int'(base) + r*16 + c));
        end
    endtask

    task automatic expect_cnt(input string nm, input int w0, input int l0, input int dw, input int dl);
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
      chk({nm, "_windows"}, 80'(nwin - w0), 80'(dw));
      chk({nm, "_last"}, 80'(nlast - l0), 80'(dl));
      chk({nm, "_drained"}, 80'(q.size()), 80'(0));
    endtask

    initial forever begin
      @(negedge clk);
      if (exp_r) begin
        chk($sformatf("reset_outputs%0d", g),
            80'({out_valid, out_last, p0, p1, p2, p3, p4, p5, p6, p7, p8}), 80'(0));
      end else begin
        chk($sformatf("valid_timing%0d", g), 80'(out_valid), 80'(exp_v));
        if (out_valid === 1'b1) begin
          win_t a, e;
          a.pix = {p0, p1, p2, p3, p4, p5, p6, p7, p8};
          a.last = out_last;
          nwin++;
          if (out_last === 1'b1) nlast++;
          seen.push_back(a);
          if (q.size() == 0) chk($sformatf("queue_underflow%0d", g), 80'(1), 80'(0));
          else begin
            e = q.pop_front();
            chk($sformatf("window%0d", g), {7'd0, a.last, a.pix}, {7'd0, e.last, e.pix});
          end
        end
      end
    end

    if (g == 0) begin : directed
      initial begin
        int w0, l0;
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        // continuous frame plus known-answer windows
        seen.delete(); w0 = nwin; l0 = nlast;
        frame(8'h00, 0, 1'b0);
        expect_cnt("s1", w0, l0, 4, 1);
        chk("s1_first", {8'd0, seen[0].pix}, {8'd0, 72'h00_01_02_10_11_12_20_21_22});
        chk("s1_lastwin", {7'd0, seen[3].last, seen[3].pix}, {7'd0, 1'b1, 72'h11_12_13_21_22_23_31_32_33});
        // toggled and random-gap valid
        w0 = nwin; l0 = nlast;
        frame(8'h00, 1, 1'b0);
        expect_cnt("s2", w0, l0, 4, 1);
        w0 = nwin; l0 = nlast;
        frame(8'h00, 2, 1'b0);
        expect_cnt("s2r", w0, l0, 4, 1);
        // back-to-back frames
        seen.delete(); w0 = nwin; l0 = nlast;
        frame(8'h00, 0, 1'b0);
        frame(8'h80, 0, 1'b0);
        expect_cnt("s3", w0, l0, 8, 2);
        chk("s3_f2_first", {8'd0, seen[4].pix}, {8'd0, 72'h80_81_82_90_91_92_A0_A1_A2});
        // reset mid-frame
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'($urandom));
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        seen.delete(); w0 = nwin; l0 = nlast;
        frame(8'h00, 0, 1'b0);
        expect_cnt("s4", w0, l0, 4, 1);
        chk("s4_first", {8'd0, seen[0].pix}, {8'd0, 72'h00_01_02_10_11_12_20_21_22});
        // rst and in_valid together: pixel dropped
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'($urandom));
        cyc(1'b1, 1'b1, 8'hFF);
        seen.delete(); w0 = nwin; l0 = nlast;
        frame(8'h00, 0, 1'b0);
        expect_cnt("s6", w0, l0, 4, 1);
        chk("s6_first", {8'd0, seen[0].pix}, {8'd0, 72'h00_01_02_10_11_12_20_21_22});
        done = 1'b1;
      end
    end else begin : random
      initial begin
        int w0, l0;
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        w0 = nwin; l0 = nlast;
        frame(8'h00, 0, 1'b1);
        expect_cnt("s5", w0, l0, (W-2)*(H-2), 1);
        done = 1'b1;
      end
    end
  end

  initial begin
    wait (cfg[0].done && cfg[1].done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL timeout: got no completion expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-scan 3x3 window generator that produces the eight-neighbour pixel set (plus centre) consumed by the Sobel edge kernel. It accepts one 8-bit pixel per valid cycle in row-major order, holds the two previous image rows in internal line buffers, and emits a registered 3x3 window for every interior pixel position. The window outputs feed the kernel's p0..p8 inputs directly.

## Interface
- IMG_W, 64, image width in pixels (>= 3)
- IMG_H, 64, image height in lines (>= 3)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_pixel is valid this cycle; always accepted (no backpressure)
- in_pixel  input  8  raster pixel, row-major, top-left first
- out_valid  output  1  window outputs valid this cycle (single-cycle pulse per window)
- out_last  output  1  qualifies out_valid; marks last window of a frame
- p0, p1, p2  output  8 each  top row of window (row y-1), columns x-1, x, x+1
- p3, p4, p5  output  8 each  middle row (row y), columns x-1, x, x+1; p4 is centre
- p6, p7, p8  output  8 each  bottom row (row y+1), columns x-1, x, x+1

## Operation
- Counters: col (0..IMG_W-1), row (0..IMG_H-1) give the position of the next pixel to be accepted. Advance only when in_valid=1. col wraps to 0 at IMG_W-1 and increments row; row wraps to 0 after (IMG_W-1, IMG_H-1) -> next pixel starts a new frame.
- Line buffers: lb_a (row r-2) and lb_b (row r-1), IMG_W x 8 each, asynchronous read, synchronous write, indexed by col. On accept: read lb_a[col], lb_b[col]; write lb_a[col] <= lb_b[col], lb_b[col] <= in_pixel.
- Shift window: 3x3 register array shifts one column left on accept; new right column = {lb_a[col], lb_b[col], in_pixel} into {p2, p5, p8}. No shift when in_valid=0.
- Window emission: accepting pixel at (col, row) with col >= 2 and row >= 2 completes window centred at (col-1, row-1); out_valid=1 next cycle. Border pixels produce no window (no padding, no replication); (IMG_W-2)*(IMG_H-2) windows per frame.
- out_last=1 with out_valid when the accepted pixel was (IMG_W-1, IMG_H-1).
- Window registers left over from the previous row's end are overwritten before any emission (col >= 2 gate), so no cross-row mixing appears on a valid window.
- Line-buffer contents are not reset; row >= 2 gate guarantees stale data is never emitted.

## Timing
- Latency: 1 cycle from accepting clk edge of the completing pixel to out_valid.
- p0..p8 are registered and hold their value until the next accept; out_valid/out_last are high for exactly one cycle per window.
- Throughput: one window per clock with continuous in_valid; gaps in in_valid stall everything without data loss.
- Reset: col=0, row=0, out_valid=0, out_last=0, p0..p8=0. Reset asserted mid-frame aborts the frame; first pixel accepted after rst deasserts is treated as (0,0) of a new frame, and no window is emitted until row 2, col 2 of that frame.
- rst and in_valid together: rst wins, pixel dropped.
- Frame boundary: last pixel of frame N and first of frame N+1 may be back-to-back; rows 0-1 of frame N+1 emit nothing.

## Test plan
- IMG_W=4, IMG_H=4, pixel = row*16+col, continuous valid -> 4 windows; first, after input 0x22, has p0..p8 = 00,01,02,10,11,12,20,21,22; last after 0x33 = 11,12,13,21,22,23,31,32,33 with out_last=1.
- Same frame with in_valid toggling 1/0 every cycle and random gaps -> identical 4 windows in order, out_valid one cycle after each completing accept, never otherwise.
- Two back-to-back frames (frame 2 pixel = 0x80+row*16+col) -> 8 windows total, out_last on 4th and 8th, frame 2 first window p0=80, p8=A2, no frame-1 data present.
- Reset after 6 pixels of a frame, then full 4x4 frame -> exactly 4 windows, first equals scenario 1 first window; all outputs 0 while rst high.
- IMG_W=64, IMG_H=64 random pixels against a software 3x3 reference model -> 3844 windows, all matching, exactly one out_last.
- in_valid=1 in the same cycle as rst=1 -> pixel ignored; next accepted pixel counted as (0,0).
